// File: rtl/button_sprite_ctrl_if.sv
// rtl/button_sprite_ctrl_if.sv - pixel/player inputs and ROM/flag outputs of the button sprite controller
interface button_sprite_ctrl_if #(
    parameter int NUM_BTN = 2
);
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [9:0]         fb_x;
    logic [9:0]         fb_y;
    logic [9:0]         wg_x;
    logic [9:0]         wg_y;
    logic [8:0]         rom_address;
    logic               btn_on;
    logic [NUM_BTN-1:0] btn_pressed;

    modport master (
        output DrawX, DrawY, fb_x, fb_y, wg_x, wg_y,
        input  rom_address, btn_on, btn_pressed
    );

    modport slave (
        input  DrawX, DrawY, fb_x, fb_y, wg_x, wg_y,
        output rom_address, btn_on, btn_pressed
    );
endinterface

// File: rtl/button_sprite_ctrl.sv
// rtl/button_sprite_ctrl.sv - press FSMs and shared ROM scheduling for NUM_BTN button sprites
// Optional BUTTON_LATCH_EN: DOWN becomes terminal until Reset (one-shot switches).
module button_sprite_ctrl #(
    parameter int                       NUM_BTN        = 2,
    parameter logic [NUM_BTN*10-1:0]    BTN_X_LIST     = {10'd140, 10'd505},
    parameter logic [NUM_BTN*10-1:0]    BTN_Y_LIST     = {10'd400, 10'd253},
    parameter int                       SPRITE_W       = 20,
    parameter int                       SPRITE_H       = 20,
    parameter int                       PRESS_DEPTH    = 4,
    parameter int                       RELEASE_FRAMES = 8
) (
    input  logic                 vga_clk,
    input  logic                 Reset,
    button_sprite_ctrl_if.slave  sprite_bus
);
    localparam int DW = $clog2(PRESS_DEPTH + 1);
    localparam int VW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [DW-1:0] PD_MAX = DW'(PRESS_DEPTH);
    localparam logic [DW-1:0] PD_M1  = DW'(PRESS_DEPTH - 1);
    localparam logic [VW-1:0] RF_M1  = VW'(RELEASE_FRAMES - 1);
    localparam logic [10:0]   W11    = 11'(SPRITE_W);
    localparam logic [10:0]   H11    = 11'(SPRITE_H);
    localparam logic [10:0]   PD11   = 11'(PRESS_DEPTH);
    localparam logic [9:0]    W10    = 10'(SPRITE_W);

    typedef enum logic [1:0] {ST_UP, ST_PRESSING, ST_DOWN, ST_RELEASING} btn_state_t;

    btn_state_t         state_q [NUM_BTN];
    btn_state_t         state_d [NUM_BTN];
    logic [DW-1:0]      depth_q [NUM_BTN];
    logic [DW-1:0]      depth_d [NUM_BTN];
    logic [VW-1:0]      vac_q   [NUM_BTN];
    logic [VW-1:0]      vac_d   [NUM_BTN];
    logic [NUM_BTN-1:0] occ;
    logic [NUM_BTN-1:0] hit;
    logic [NUM_BTN-1:0] pressed_d;
    logic [8:0]         rom_d;
    logic [9:0]         bx, by, dx, dy;
    logic               frame_tick;
    logic               btn_on_q;
    logic [NUM_BTN-1:0] btn_pressed_q;

    assign frame_tick = (sprite_bus.DrawX == 10'd0) && (sprite_bus.DrawY == 10'd480);

    // Foot zone reaches 2 px above the cap and down to the fully sunk top; 11-bit math avoids underflow.
    function automatic logic foot_in(input logic [9:0] fx, input logic [9:0] fy,
                                     input logic [9:0] ox, input logic [9:0] oy);
        return ({1'b0, fx} >= {1'b0, ox}) && ({1'b0, fx} < {1'b0, ox} + W11) &&
               ({1'b0, fy} + 11'd2 >= {1'b0, oy}) && ({1'b0, fy} <= {1'b0, oy} + PD11);
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            occ[i] = foot_in(sprite_bus.fb_x, sprite_bus.fb_y, BTN_X_LIST[i*10 +: 10], BTN_Y_LIST[i*10 +: 10]) ||
                     foot_in(sprite_bus.wg_x, sprite_bus.wg_y, BTN_X_LIST[i*10 +: 10], BTN_Y_LIST[i*10 +: 10]);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_UP;
                depth_q[i] <= '0;
                vac_q[i]   <= '0;
            end
            btn_on_q      <= 1'b0;
            btn_pressed_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                depth_q[i] <= depth_d[i];
                vac_q[i]   <= vac_d[i];
            end
            btn_on_q      <= |hit;
            btn_pressed_q <= pressed_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            depth_d[i] = depth_q[i];
            vac_d[i]   = vac_q[i];
            if (frame_tick) begin
                case (state_q[i])
                    ST_UP, ST_PRESSING, ST_RELEASING: begin
                        // Pressing always resumes from the current depth, so a re-press never jumps back to 1.
                        if (occ[i]) begin
                            vac_d[i] = '0;
                            if (depth_q[i] >= PD_M1) begin
                                depth_d[i] = PD_MAX;
                                state_d[i] = ST_DOWN;
                            end else begin
                                depth_d[i] = depth_q[i] + 1'b1;
                                state_d[i] = ST_PRESSING;
                            end
                        end else if (state_q[i] == ST_PRESSING) begin
                            state_d[i] = ST_RELEASING;
                        end else if (state_q[i] == ST_RELEASING) begin
                            if (depth_q[i] <= DW'(1)) begin
                                depth_d[i] = '0;
                                state_d[i] = ST_UP;
                            end else begin
                                depth_d[i] = depth_q[i] - 1'b1;
                            end
                        end
                    end
                    ST_DOWN: begin
`ifdef BUTTON_LATCH_EN
                        state_d[i] = ST_DOWN;
`else
                        if (occ[i]) begin
                            vac_d[i] = '0;
                        end else if (vac_q[i] >= RF_M1) begin
                            vac_d[i]   = '0;
                            state_d[i] = ST_RELEASING;
                        end else begin
                            vac_d[i] = vac_q[i] + 1'b1;
                        end
`endif
                    end
                    default: state_d[i] = ST_UP;
                endcase
            end
        end
    end

    // Descending scan so the lowest-index hit is written last and owns the ROM address.
    always_comb begin
        hit       = '0;
        pressed_d = '0;
        rom_d     = '0;
        bx        = '0;
        by        = '0;
        dx        = '0;
        dy        = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            pressed_d[i] = (state_d[i] == ST_DOWN);
            bx = BTN_X_LIST[i*10 +: 10];
            by = BTN_Y_LIST[i*10 +: 10];
            hit[i] = ({1'b0, sprite_bus.DrawX} >= {1'b0, bx}) &&
                     ({1'b0, sprite_bus.DrawX} <  {1'b0, bx} + W11) &&
                     ({1'b0, sprite_bus.DrawY} >= {1'b0, by} + 11'(depth_q[i])) &&
                     ({1'b0, sprite_bus.DrawY} <  {1'b0, by} + H11);
            if (hit[i]) begin
                dx    = sprite_bus.DrawX - bx;
                dy    = sprite_bus.DrawY - by - 10'(depth_q[i]);
                rom_d = 9'(dx + dy * W10);
            end
        end
    end

    assign sprite_bus.rom_address = rom_d;
    assign sprite_bus.btn_on      = btn_on_q;
    assign sprite_bus.btn_pressed = btn_pressed_q;
endmodule
